// File: rtl/cordic_vectoring_if.sv
// Handshake and result bundle between a requester and the vectoring CORDIC core.
// The requester drives the vector and START; the core returns status and results.
interface cordic_vectoring_if #(
    parameter int W = 8
);
    logic [W-1:0] X_IN;
    logic [W-1:0] Y_IN;
    logic         START;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] ANGLE;
    logic [W+1:0] MAG;

    modport master (
        output X_IN, Y_IN, START,
        input  BUSY, DONE, ANGLE, MAG
    );

    modport slave (
        input  X_IN, Y_IN, START,
        output BUSY, DONE, ANGLE, MAG
    );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: first-quadrant (X, Y) -> angle (256 = 90 deg)
// and gain-scaled magnitude, one micro-rotation per clock.
module cordic_vectoring #(
    parameter int ITER = 8,
    parameter int W    = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    cordic_vectoring_if.slave bus
);
    localparam int XW = W + 3;
    localparam int ZW = W + 2;
    localparam logic [2:0] LAST_IDX = 3'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // atan(2^-i) in the 256-per-quadrant angle encoding
    function automatic logic signed [ZW-1:0] atan_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    atan_lut = 10'sd128;
            3'd1:    atan_lut = 10'sd76;
            3'd2:    atan_lut = 10'sd40;
            3'd3:    atan_lut = 10'sd20;
            3'd4:    atan_lut = 10'sd10;
            3'd5:    atan_lut = 10'sd5;
            3'd6:    atan_lut = 10'sd3;
            3'd7:    atan_lut = 10'sd1;
            default: atan_lut = 10'sd0;
        endcase
    endfunction

    function automatic logic [W-1:0] clamp_angle(input logic signed [ZW-1:0] z);
        if (z[ZW-1]) begin
            clamp_angle = {W{1'b0}};
        end else if (z[ZW-2:W] != 2'b00) begin
            clamp_angle = {W{1'b1}};
        end else begin
            clamp_angle = z[W-1:0];
        end
    endfunction

    state_t                state_q, state_d;
    logic signed [XW-1:0]  x_q, x_d;
    logic signed [XW-1:0]  y_q, y_d;
    logic signed [ZW-1:0]  z_q, z_d;
    logic [2:0]            i_q, i_d;
    logic                  zero_q, zero_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [W-1:0]          angle_q, angle_d;
    logic [W+1:0]          mag_q, mag_d;

    logic signed [XW-1:0]  x_sh_s, y_sh_s, x_rot_s, y_rot_s;
    logic signed [ZW-1:0]  z_rot_s;
    logic                  y_pos_s;

    // One micro-rotation from the current x/y/z; both x and y use old values
    always_comb begin
        x_sh_s  = x_q >>> i_q;
        y_sh_s  = y_q >>> i_q;
        y_pos_s = !y_q[XW-1] && (y_q != {XW{1'b0}});
        if (y_pos_s) begin
            x_rot_s = x_q + y_sh_s;
            y_rot_s = y_q - x_sh_s;
            z_rot_s = z_q + atan_lut(i_q);
        end else begin
            x_rot_s = x_q - y_sh_s;
            y_rot_s = y_q + x_sh_s;
            z_rot_s = z_q - atan_lut(i_q);
        end
    end

    // Next-state and output-register logic
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        zero_d  = zero_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        angle_d = angle_q;
        mag_d   = mag_q;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    x_d     = {3'b000, bus.X_IN};
                    y_d     = {3'b000, bus.Y_IN};
                    z_d     = {ZW{1'b0}};
                    i_d     = 3'd0;
                    zero_d  = (bus.X_IN == {W{1'b0}}) && (bus.Y_IN == {W{1'b0}});
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                x_d = x_rot_s;
                y_d = y_rot_s;
                z_d = z_rot_s;
                i_d = i_q + 3'd1;
                if (i_q == LAST_IDX) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    // A zero vector has no defined angle; report a clean zero result
                    if (zero_q) begin
                        angle_d = {W{1'b0}};
                        mag_d   = {(W+2){1'b0}};
                    end else begin
                        angle_d = clamp_angle(z_rot_s);
                        mag_d   = x_rot_s[W+1:0];
                    end
                end else begin
                    busy_d = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            x_q     <= {XW{1'b0}};
            y_q     <= {XW{1'b0}};
            z_q     <= {ZW{1'b0}};
            i_q     <= 3'd0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            angle_q <= {W{1'b0}};
            mag_q   <= {(W+2){1'b0}};
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
        end
    end

    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
    assign bus.ANGLE = angle_q;
    assign bus.MAG   = mag_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: hand-derived angle/magnitude windows,
// latency, back-to-back START handling and mid-run reset.
module tb_cordic_vectoring;
    logic CLK;
    logic RESET;
    int   checks;
    int   failures;

    cordic_vectoring_if #(.W(8)) bus ();

    cordic_vectoring #(.ITER(8), .W(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=[%0d,%0d]", tag, obs, lo, hi);
        end
    endtask

    // Issue one request, wait (bounded) for DONE, return results and timing
    task automatic run_op(input int xv, input int yv,
                          output int ang, output int mg, output int lat, output int bcnt);
        bus.X_IN  = 8'(xv);
        bus.Y_IN  = 8'(yv);
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.X_IN  = 8'd17;
        bus.Y_IN  = 8'd99;
        lat  = -1;
        bcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.BUSY) bcnt++;
            tick();
            if (bus.DONE) begin
                lat = k;
                break;
            end
        end
        ang = int'(bus.ANGLE);
        mg  = int'(bus.MAG);
    endtask

    task automatic op_checked(input string tag, input int xv, input int yv,
                              input int alo, input int ahi, input int mlo, input int mhi);
        int ang, mg, lat, bcnt;
        run_op(xv, yv, ang, mg, lat, bcnt);
        check_eq({tag, "_latency"}, lat, 8);
        check_eq({tag, "_busy_cycles"}, bcnt, 8);
        check_eq({tag, "_busy_in_done"}, int'(bus.BUSY), 0);
        check_rng({tag, "_angle"}, ang, alo, ahi);
        check_rng({tag, "_mag"}, mg, mlo, mhi);
        tick();
        check_eq({tag, "_done_one_cycle"}, int'(bus.DONE), 0);
    endtask

    initial begin
        int dcyc[4];
        int dang[4];
        int dmag[4];
        int nd;
        int ndone;
        checks   = 0;
        failures = 0;
        RESET     = 1'b0;
        bus.START = 1'b0;
        bus.X_IN  = 8'd0;
        bus.Y_IN  = 8'd0;
        tick();
        tick();
        check_eq("rst_busy", int'(bus.BUSY), 0);
        check_eq("rst_done", int'(bus.DONE), 0);
        check_eq("rst_angle", int'(bus.ANGLE), 0);
        check_eq("rst_mag", int'(bus.MAG), 0);
        RESET = 1'b1;
        tick();

        op_checked("x200_y0", 200, 0, 0, 3, 326, 332);
        op_checked("x0_y200", 0, 200, 252, 255, 326, 332);
        op_checked("x100_y100", 100, 100, 125, 131, 230, 236);
        op_checked("x173_y100", 173, 100, 82, 88, 326, 332);
        op_checked("zero_vec", 0, 0, 0, 0, 0, 0);

        // START held high: accepts at cycles 0, 10, 20; DONE cycle must not accept
        nd = 0;
        bus.X_IN  = 8'd200;
        bus.Y_IN  = 8'd0;
        bus.START = 1'b1;
        tick();
        bus.X_IN = 8'd0;
        bus.Y_IN = 8'd200;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            tick();
            if (bus.DONE && nd < 4) begin
                dcyc[nd] = cyc;
                dang[nd] = int'(bus.ANGLE);
                dmag[nd] = int'(bus.MAG);
                nd++;
            end
            if (cyc == 10) begin
                bus.X_IN = 8'd100;
                bus.Y_IN = 8'd100;
            end
            if (cyc == 28) bus.START = 1'b0;
        end
        check_eq("b2b_done_count", nd, 3);
        if (nd == 3) begin
            check_eq("b2b_done0_cycle", dcyc[0], 8);
            check_eq("b2b_done1_cycle", dcyc[1], 18);
            check_eq("b2b_done2_cycle", dcyc[2], 28);
            check_rng("b2b_angle0", dang[0], 0, 3);
            check_rng("b2b_mag0", dmag[0], 326, 332);
            check_rng("b2b_angle1", dang[1], 252, 255);
            check_rng("b2b_mag1", dmag[1], 326, 332);
            check_rng("b2b_angle2", dang[2], 125, 131);
            check_rng("b2b_mag2", dmag[2], 230, 236);
        end

        // Reset during iteration 4 aborts the run
        bus.X_IN  = 8'd50;
        bus.Y_IN  = 8'd30;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_eq("pre_abort_busy", int'(bus.BUSY), 1);
        RESET = 1'b0;
        tick();
        check_eq("abort_busy", int'(bus.BUSY), 0);
        check_eq("abort_done", int'(bus.DONE), 0);
        check_eq("abort_angle", int'(bus.ANGLE), 0);
        check_eq("abort_mag", int'(bus.MAG), 0);
        RESET = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.DONE) ndone++;
        end
        check_eq("abort_no_done", ndone, 0);

        op_checked("x255_y255", 255, 255, 125, 131, 590, 596);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
